// File: rtl/fpu_bcd_convert.sv
// Sequential packed-BCD converter for the FPU datapath: binary->BCD by double-dabble,
// BCD->binary by multiply-accumulate, with overflow/invalid detection and indefinite result.
module fpu_bcd_convert #(
   parameter int BIN_WIDTH = 64,
   parameter int DIGITS    = 18,
   parameter int BCD_WIDTH = DIGITS*4+8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 mode,
   input  logic [BIN_WIDTH-1:0] binary_in,
   input  logic                 sign_in,
   input  logic [BCD_WIDTH-1:0] bcd_in,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [BCD_WIDTH-1:0] bcd_out,
   output logic [BIN_WIDTH-1:0] binary_out,
   output logic                 sign_out
);

   // Working register must hold every digit of 2^BIN_WIDTH-1, always at least one above DIGITS.
   localparam int B2D_CALC   = (BIN_WIDTH*30103 + 99999) / 100000;
   localparam int B2D_DIGITS = (B2D_CALC > DIGITS) ? B2D_CALC : DIGITS + 1;
   localparam int B2D_W      = B2D_DIGITS*4;
   localparam int DIG_W      = DIGITS*4;
   localparam int MAX_N      = (BIN_WIDTH > DIGITS) ? BIN_WIDTH : DIGITS;
   localparam int CNT_W      = $clog2(MAX_N + 1);

   localparam logic [CNT_W-1:0]     B2D_LAST  = CNT_W'(BIN_WIDTH);
   localparam logic [CNT_W-1:0]     D2B_LAST  = CNT_W'(DIGITS);
   localparam logic [BCD_WIDTH-1:0] BCD_INDEF = {16'hFFFF, 4'hC, {(BCD_WIDTH-20){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_B2D  = 2'd1,
      ST_D2B  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t               state_r;
   state_t               next_state_s;
   logic [CNT_W-1:0]     cnt_r;
   logic [BIN_WIDTH-1:0] bin_r;
   logic [B2D_W-1:0]     bcd_r;
   logic [DIG_W-1:0]     dig_r;
   logic [BIN_WIDTH-1:0] acc_r;
   logic                 invalid_r;
   logic                 sign_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 error_r;
   logic [BCD_WIDTH-1:0] bcd_out_r;
   logic [BIN_WIDTH-1:0] binary_out_r;
   logic                 sign_out_r;

   logic                 accept_s;
   logic                 b2d_last_s;
   logic                 d2b_last_s;
   logic [B2D_W-1:0]     adj_s;
   logic [B2D_W-1:0]     bcd_shift_s;
   logic [3:0]           digit_s;
   logic [BIN_WIDTH-1:0] acc_next_s;
   logic                 overflow_s;
   logic                 unused_s;

   function automatic logic [B2D_W-1:0] dabble_adjust(input logic [B2D_W-1:0] v);
      logic [B2D_W-1:0] r;
      r = v;
      for (int i = 0; i < B2D_DIGITS; i++) begin
         if (r[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
         end else begin
            r[i*4 +: 4] = r[i*4 +: 4];
         end
      end
      return r;
   endfunction

   assign accept_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign b2d_last_s  = (cnt_r == B2D_LAST);
   assign d2b_last_s  = (cnt_r == D2B_LAST);
   assign adj_s       = dabble_adjust(bcd_r);
   assign bcd_shift_s = {adj_s[B2D_W-2:0], bin_r[BIN_WIDTH-1]};
   assign digit_s     = dig_r[DIG_W-1 -: 4];
   assign acc_next_s  = (acc_r << 3) + (acc_r << 1) + {{(BIN_WIDTH-4){1'b0}}, digit_s};
   assign overflow_s  = |bcd_r[B2D_W-1:DIG_W];
   assign unused_s    = ^{bcd_in[BCD_WIDTH-2:DIG_W], adj_s[B2D_W-1]};

   assign busy       = busy_r;
   assign done       = done_r;
   assign error      = error_r;
   assign bcd_out    = bcd_out_r;
   assign binary_out = binary_out_r;
   assign sign_out   = sign_out_r;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode; each loop state exits on its terminal count
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               next_state_s = mode ? ST_D2B : ST_B2D;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_B2D: begin
            if (b2d_last_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_B2D;
            end
         end
         ST_D2B: begin
            if (d2b_last_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_D2B;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Datapath, handshake and result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r        <= {CNT_W{1'b0}};
         bin_r        <= {BIN_WIDTH{1'b0}};
         bcd_r        <= {B2D_W{1'b0}};
         dig_r        <= {DIG_W{1'b0}};
         acc_r        <= {BIN_WIDTH{1'b0}};
         invalid_r    <= 1'b0;
         sign_r       <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
         bcd_out_r    <= {BCD_WIDTH{1'b0}};
         binary_out_r <= {BIN_WIDTH{1'b0}};
         sign_out_r   <= 1'b0;
      end else if (accept_s) begin
         cnt_r     <= {CNT_W{1'b0}};
         bin_r     <= binary_in;
         bcd_r     <= {B2D_W{1'b0}};
         dig_r     <= bcd_in[DIG_W-1:0];
         acc_r     <= {BIN_WIDTH{1'b0}};
         invalid_r <= 1'b0;
         sign_r    <= mode ? bcd_in[BCD_WIDTH-1] : sign_in;
         busy_r    <= 1'b1;
         done_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_B2D: begin
               if (b2d_last_s) begin
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
                  error_r   <= overflow_s;
                  bcd_out_r <= overflow_s ? BCD_INDEF
                             : {sign_r, {(BCD_WIDTH-1-DIG_W){1'b0}}, bcd_r[DIG_W-1:0]};
               end else begin
                  bcd_r <= bcd_shift_s;
                  bin_r <= bin_r << 1;
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_D2B: begin
               if (d2b_last_s) begin
                  busy_r       <= 1'b0;
                  done_r       <= 1'b1;
                  error_r      <= invalid_r;
                  binary_out_r <= invalid_r ? {BIN_WIDTH{1'b0}} : acc_r;
                  sign_out_r   <= sign_r;
               end else begin
                  acc_r     <= acc_next_s;
                  dig_r     <= dig_r << 4;
                  invalid_r <= invalid_r | (digit_s > 4'd9);
                  cnt_r     <= cnt_r + CNT_W'(1);
               end
            end
            ST_DONE: begin
               done_r <= 1'b0;
            end
            default: begin
               done_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_bcd_convert.sv
// Scoreboard bench for fpu_bcd_convert: expectations are queued at issue time and
// checked when done pulses, including latency, output holding, handshake and reset abort.
module tb_fpu_bcd_convert;

   logic        clk;
   logic        reset;
   logic        start;
   logic        mode;
   logic [63:0] binary_in;
   logic        sign_in;
   logic [79:0] bcd_in;
   logic        busy;
   logic        done;
   logic        error;
   logic [79:0] bcd_out;
   logic [63:0] binary_out;
   logic        sign_out;

   typedef struct {
      logic [79:0] bcd;
      logic [63:0] bin;
      logic        sign;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          tests;
   int          fails;
   int          cyc;
   int          t0;
   logic [79:0] model_bcd;
   logic [63:0] model_bin;
   logic        model_sign;

   fpu_bcd_convert dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .binary_in(binary_in), .sign_in(sign_in), .bcd_in(bcd_in),
      .busy(busy), .done(done), .error(error), .bcd_out(bcd_out),
      .binary_out(binary_out), .sign_out(sign_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference binary->BCD by repeated division; returns {error, bcd}
   function automatic logic [80:0] b2d_ref(input logic [63:0] v, input logic s);
      logic [63:0] x;
      logic [79:0] r;
      x = v;
      r = 80'd0;
      for (int i = 0; i < 18; i++) begin
         r[i*4 +: 4] = 4'(x % 64'd10);
         x = x / 64'd10;
      end
      if (x != 64'd0) return {1'b1, 80'hFFFFC000000000000000};
      r[79] = s;
      return {1'b0, r};
   endfunction

   // Reference BCD->binary; returns {error, sign, magnitude}
   function automatic logic [65:0] d2b_ref(input logic [79:0] d);
      logic [63:0] acc;
      logic        bad;
      logic [3:0]  dg;
      acc = 64'd0;
      bad = 1'b0;
      for (int i = 17; i >= 0; i--) begin
         dg = d[i*4 +: 4];
         if (dg > 4'd9) bad = 1'b1;
         acc = acc * 64'd10 + 64'(dg);
      end
      return {bad, d[79], bad ? 64'd0 : acc};
   endfunction

   task automatic issue(input logic m, input logic [63:0] b, input logic s,
                        input logic [79:0] d, input bit hold);
      exp_t        e;
      logic [80:0] r0;
      logic [65:0] r1;
      if (m == 1'b0) begin
         r0 = b2d_ref(b, s);
         model_bcd = r0[79:0];
         e.err = r0[80];
         e.lat = 65;
      end else begin
         r1 = d2b_ref(d);
         model_bin = r1[63:0];
         model_sign = r1[64];
         e.err = r1[65];
         e.lat = 19;
      end
      e.bcd = model_bcd;
      e.bin = model_bin;
      e.sign = model_sign;
      sb.push_back(e);
      mode = m; binary_in = b; sign_in = s; bcd_in = d; start = 1'b1;
      @(posedge clk); #1;
      t0 = cyc;
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_result(input string name, input bit check_drop);
      exp_t e;
      int   n;
      int   gap;
      n = 0;
      gap = 0;
      while (done !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (done !== 1'b1 && busy !== 1'b1) gap++;
      end
      e = sb.pop_front();
      tests++;
      if (done !== 1'b1) begin
         fails++;
         $display("FAIL %s timeout: done not seen within %0d cycles", name, n);
      end else begin
         if (cyc - t0 !== e.lat) begin
            fails++; $display("FAIL %s latency: got %0d want %0d", name, cyc - t0, e.lat);
         end
         tests++;
         if (bcd_out !== e.bcd) begin
            fails++; $display("FAIL %s bcd_out: got %h want %h", name, bcd_out, e.bcd);
         end
         tests++;
         if (binary_out !== e.bin) begin
            fails++; $display("FAIL %s binary_out: got %h want %h", name, binary_out, e.bin);
         end
         tests++;
         if (sign_out !== e.sign) begin
            fails++; $display("FAIL %s sign_out: got %b want %b", name, sign_out, e.sign);
         end
         tests++;
         if (error !== e.err) begin
            fails++; $display("FAIL %s error: got %b want %b", name, error, e.err);
         end
         tests++;
         if (busy !== 1'b0 || gap !== 0) begin
            fails++; $display("FAIL %s busy: got busy=%b gaps=%0d want busy=0 gaps=0", name, busy, gap);
         end
         if (check_drop) begin
            @(posedge clk); #1;
            tests++;
            if (done !== 1'b0 || error !== e.err) begin
               fails++;
               $display("FAIL %s pulse/hold: got done=%b error=%b want done=0 error=%b",
                        name, done, error, e.err);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; mode = 1'b0;
      binary_in = 64'd0; sign_in = 1'b0; bcd_in = 80'd0;
      model_bcd = 80'd0; model_bin = 64'd0; model_sign = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({busy, done, error, sign_out} !== 4'b0000 || bcd_out !== 80'd0 || binary_out !== 64'd0) begin
         fails++;
         $display("FAIL reset_state: got busy=%b done=%b err=%b sign=%b bcd=%h bin=%h want all 0",
                  busy, done, error, sign_out, bcd_out, binary_out);
      end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_b2d();
      issue(1'b0, 64'd123, 1'b0, 80'd0, 1'b0);
      wait_result("b2d_123", 1'b1);
      issue(1'b0, 64'd456, 1'b1, 80'd0, 1'b0);
      wait_result("b2d_neg456", 1'b1);
      issue(1'b0, 64'd0, 1'b1, 80'd0, 1'b0);
      wait_result("b2d_negzero", 1'b1);
      issue(1'b0, 64'd987654321098765432, 1'b0, 80'd0, 1'b0);
      wait_result("b2d_long", 1'b1);
   endtask

   task automatic test_b2d_boundary();
      issue(1'b0, 64'h0DE0B6B3A763FFFF, 1'b0, 80'd0, 1'b0);
      wait_result("b2d_max", 1'b1);
      issue(1'b0, 64'h0DE0B6B3A7640000, 1'b0, 80'd0, 1'b0);
      wait_result("b2d_ovf", 1'b1);
      issue(1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 80'd0, 1'b0);
      wait_result("b2d_allones", 1'b1);
   endtask

   task automatic test_d2b();
      issue(1'b1, 64'd0, 1'b0, 80'h80000000000000000999, 1'b0);
      wait_result("d2b_neg999", 1'b1);
      issue(1'b1, 64'd0, 1'b0, 80'h0000000000000000000A, 1'b0);
      wait_result("d2b_invalid", 1'b1);
      issue(1'b1, 64'd0, 1'b0, 80'h7F999999999999999999, 1'b0);
      wait_result("d2b_max_ignored", 1'b1);
      issue(1'b1, 64'd0, 1'b0, 80'h00123456789012345678, 1'b0);
      wait_result("d2b_long", 1'b1);
      issue(1'b0, 64'd31, 1'b0, 80'd0, 1'b0);
      wait_result("b2d_after_d2b", 1'b1);
   endtask

   task automatic test_ignore_start();
      issue(1'b0, 64'd5000, 1'b0, 80'd0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1; mode = 1'b1; binary_in = 64'd999; sign_in = 1'b1;
      bcd_in = 80'h80000000000000000321;
      @(posedge clk); #1;
      start = 1'b0;
      wait_result("ignore_start", 1'b1);
   endtask

   task automatic test_back_to_back();
      issue(1'b0, 64'd7, 1'b0, 80'd0, 1'b1);
      wait_result("b2b_first", 1'b0);
      issue(1'b1, 64'd0, 1'b0, 80'h00000000000000000042, 1'b0);
      tests++;
      if (busy !== 1'b1) begin
         fails++; $display("FAIL b2b_restart busy: got %b want 1", busy);
      end
      wait_result("b2b_second", 1'b1);
   endtask

   task automatic test_reset_abort();
      int seen;
      issue(1'b0, 64'd777, 1'b1, 80'd0, 1'b0);
      repeat (20) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      void'(sb.pop_back());
      model_bcd = 80'd0; model_bin = 64'd0; model_sign = 1'b0;
      tests++;
      if ({busy, done, error, sign_out} !== 4'b0000 || bcd_out !== 80'd0 || binary_out !== 64'd0) begin
         fails++;
         $display("FAIL abort_outputs: got busy=%b done=%b err=%b bcd=%h bin=%h want all 0",
                  busy, done, error, bcd_out, binary_out);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      seen = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      tests++;
      if (seen !== 0) begin
         fails++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
      end
      issue(1'b0, 64'd1, 1'b0, 80'd0, 1'b0);
      wait_result("after_reset_one", 1'b1);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      cyc = 0;
      t0 = 0;
      test_reset();
      test_b2d();
      test_b2d_boundary();
      test_d2b();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
